pipe_fetch_queue: RTL and testbench

//  Instruction prefetch queue between a variable-latency instruction memory and the IF/ID register.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fq_fifo.sv | 73 +++++++
 rtl/pipe_fetch_queue_chk.sv | 29 ++
 rtl/pipe_fetch_queue.sv | 221 ++++++++++++++++++++++
 tb/tb_pipe_fetch_queue.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction prefetch queue:
//   - fq_state_e   : prefetch FSM encoding (IDLE / FETCH / DRAIN)
//   - RESET_PC_DEF : default first fetch address after reset
//   - INST_W       : instruction word width
//   - PC_STEP      : distance between sequential instruction words
//   - fq_entry_t   : one queue entry {pc, inst}
//   - pc_advance() : next sequential PC (wraps modulo 2^32)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int          INST_W       = 32;
  localparam int          ENTRY_W      = 32 + INST_W;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  function automatic logic [31:0] pc_advance(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// -----------------------------------------------------------------------------
// fq_fifo
//   DEPTH-entry ring buffer holding {pc, inst} words for the prefetch queue.
//   Pointers wrap modulo DEPTH; 'clear' empties the queue in one cycle and
//   has priority over push/pop.
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   push   in   write wdata at the tail
//   pop    in   drop the head entry
//   clear  in   flush all entries
//   wdata  in   entry to write
//   rdata  out  head entry (meaningful when count != 0)
//   count  out  number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic [CW-1:0]      count
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates their use
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/pipe_fetch_queue_chk.sv
// -----------------------------------------------------------------------------
// pipe_fetch_queue_chk
//   Protocol checker bound inside pipe_fetch_queue.
//   - the queue is never written while full
//   - in-flight requests plus buffered words never exceed DEPTH
// Ports
//   clk, rst     clock and asynchronous active-low reset
//   push         queue write strobe
//   count        queue occupancy
//   outstanding  requests issued and not yet answered
// -----------------------------------------------------------------------------
module pipe_fetch_queue_chk #(
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic [CW-1:0] count,
  input logic [CW-1:0] outstanding
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == CW'(DEPTH))));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
    (({1'b0, outstanding} + {1'b0, count}) <= (CW+1)'(DEPTH)));

endmodule

// File: rtl/pipe_fetch_queue.sv
// -----------------------------------------------------------------------------
// pipe_fetch_queue
//   Instruction prefetch queue between a variable-latency IMEM and IF/ID.
//   Issues in-order word fetches from its own fetch PC while the sum of
//   in-flight requests and buffered words stays below DEPTH, buffers the
//   returned words with their PCs and hands them to IF over valid/ready.
//   A redirect flushes the queue, retargets both PC counters and drops the
//   responses of every request still in flight (DRAIN state).
//
//   Optional build macro FQ_BYPASS_EN: when the queue is empty, a fresh
//   response is presented to IF in the same cycle and, if IF takes it, is
//   never written into the queue.
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   imem_req_valid/ready/addr     fetch request channel
//   imem_rsp_valid/data           in-order response, cannot be stalled
//   redirect, redirect_pc         taken control transfer from ID (pulse)
//   if_valid, if_ready            head handshake with IF
//   if_inst, if_pc, if_pc4        head instruction, its PC and PC+4
// -----------------------------------------------------------------------------
module pipe_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc4
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  fq_state_e     state_r;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   rsp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] discard_r;

  logic [CW-1:0]      fifo_count_s;
  logic [ENTRY_W-1:0] fifo_rdata_s;
  fq_entry_t          head_s;
  fq_entry_t          wentry_s;

  logic          redir_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_dec_s;
  logic          rsp_accept_s;
  logic          head_valid_s;
  logic          bypass_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   sel_pc_s;
  logic [31:0]   sel_inst_s;
  logic [CW-1:0] outstanding_nxt_s;
  logic [CW-1:0] discard_nxt_s;
  logic [31:0]   fetch_pc_nxt_s;
  logic [31:0]   rsp_pc_nxt_s;

  // A redirect only takes effect once the FSM has left IDLE.
  assign redir_s = redirect & (state_r != ST_IDLE);

  // Credit rule: in-flight plus buffered never exceeds DEPTH, so every
  // response is guaranteed a queue slot.
  assign req_valid_s = (state_r == ST_FETCH) & ((outstanding_r + fifo_count_s) < DEPTH_C) & ~redirect;
  assign req_fire_s  = req_valid_s & imem_req_ready;

  // Any response retires one outstanding request; only FETCH-state
  // responses outside a redirect cycle carry useful data.
  assign rsp_dec_s    = imem_rsp_valid & (state_r != ST_IDLE) & (outstanding_r != ZERO_C);
  assign rsp_accept_s = rsp_dec_s & (state_r == ST_FETCH) & ~redir_s;

  assign head_valid_s = (fifo_count_s != ZERO_C) & ~redir_s;

`ifdef FQ_BYPASS_EN
  assign bypass_s = rsp_accept_s & (fifo_count_s == ZERO_C);
`else
  assign bypass_s = 1'b0;
`endif

  assign pop_s  = head_valid_s & if_ready;
  assign push_s = rsp_accept_s & ~(bypass_s & if_ready);

  assign wentry_s.pc   = rsp_pc_r;
  assign wentry_s.inst = imem_rsp_data;
  assign head_s        = fq_entry_t'(fifo_rdata_s);

  fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .clear (redir_s),
    .wdata (wentry_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s)
  );

  // Head selection: queued word first, otherwise the bypassed response
  always_comb begin
    sel_pc_s   = 32'h0000_0000;
    sel_inst_s = 32'h0000_0000;
    if (head_valid_s) begin
      sel_pc_s   = head_s.pc;
      sel_inst_s = head_s.inst;
    end else if (bypass_s) begin
      sel_pc_s   = rsp_pc_r;
      sel_inst_s = imem_rsp_data;
    end else begin
      sel_pc_s   = 32'h0000_0000;
      sel_inst_s = 32'h0000_0000;
    end
  end

  assign if_valid       = head_valid_s | bypass_s;
  assign if_pc          = sel_pc_s;
  assign if_inst        = sel_inst_s;
  assign if_pc4         = (head_valid_s | bypass_s) ? pc_advance(sel_pc_s) : 32'h0000_0000;
  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;

  // Counter and PC next-state values
  always_comb begin
    outstanding_nxt_s = outstanding_r + {{(CW-1){1'b0}}, req_fire_s} - {{(CW-1){1'b0}}, rsp_dec_s};
    discard_nxt_s     = discard_r;
    fetch_pc_nxt_s    = fetch_pc_r;
    rsp_pc_nxt_s      = rsp_pc_r;

    // Everything still in flight after this cycle belongs to the old path.
    if (redir_s) begin
      discard_nxt_s = outstanding_r - {{(CW-1){1'b0}}, rsp_dec_s};
    end else if ((state_r == ST_DRAIN) && rsp_dec_s) begin
      discard_nxt_s = discard_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      discard_nxt_s = discard_r;
    end

    if (redir_s) begin
      fetch_pc_nxt_s = redirect_pc;
    end else if (req_fire_s) begin
      fetch_pc_nxt_s = pc_advance(fetch_pc_r);
    end else begin
      fetch_pc_nxt_s = fetch_pc_r;
    end

    // rsp_pc tracks the PC of the next word that will be accepted.
    if (redir_s) begin
      rsp_pc_nxt_s = redirect_pc;
    end else if (rsp_accept_s) begin
      rsp_pc_nxt_s = pc_advance(rsp_pc_r);
    end else begin
      rsp_pc_nxt_s = rsp_pc_r;
    end
  end

  // Prefetch FSM and its counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= ZERO_C;
      discard_r     <= ZERO_C;
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      rsp_pc_r      <= rsp_pc_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_nxt_s;
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_FETCH;
        end
        ST_FETCH: begin
          if (redir_s && (discard_nxt_s != ZERO_C)) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (discard_nxt_s == ZERO_C) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  pipe_fetch_queue_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .count       (fifo_count_s),
    .outstanding (outstanding_r)
  );

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_pipe_fetch_queue
//   Self-checking bench for pipe_fetch_queue. The IMEM is modelled as an
//   in-order list of pending requests, each tagged with the redirect epoch it
//   was issued in; the expected IF stream is a plain sequential PC counter
//   restarted by every redirect/reset, with instruction words derived from the
//   address. Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_pipe_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect       = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        if_valid;
  logic        if_ready       = 1'b0;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  always #5 clk = ~clk;

  pipe_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } req_t;

  req_t        pend[$];
  int          epoch = 0;
  int          buffered = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          ndeliv = 0;
  int          n_dut_req = 0;
  int          lat_min = 2;
  int          lat_max = 2;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc = RPC;
  logic [31:0] exp_req = RPC;
  bit          first = 1'b1;
  bit          obs_rv = 1'b0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    #1;
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc4", if_pc4, 32'h0);
    pend.delete();
    epoch++;
    buffered = 0;
    exp_pc = RPC;
    exp_req = RPC;
    last_due = cyc;
    first = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, update it.
  task automatic step(input bit rr, input bit ir, input bit rd_in, input logic [31:0] tgt);
    bit rd, rsp_now, cur, exp_ifv, exp_rv, pop_fire;
    int st, lat, due;
    req_t r;
    @(negedge clk);
    rd = rd_in && !first;
    rsp_now = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? memw(pend[0].addr) : $urandom;
    imem_req_ready = rr;
    if_ready       = ir;
    redirect       = rd;
    redirect_pc    = rd ? tgt : $urandom;
    #1;
    st  = stale_cnt();
    cur = rsp_now && (pend[0].ep == epoch);
    exp_ifv = !rd && (buffered > 0);
`ifdef FQ_BYPASS_EN
    if (!rd && cur && buffered == 0) exp_ifv = 1'b1;
`endif
    exp_rv = !first && !rd && (st == 0) && ((pend.size() + buffered) < DEPTH);
    chk("if_valid", if_valid, exp_ifv);
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_ifv) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_inst", if_inst, memw(exp_pc));
      chk("if_pc4", if_pc4, exp_pc + 32'd4);
    end
    if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
    obs_rv = imem_req_valid;
    if (imem_req_valid && rr) n_dut_req++;
    pop_fire = exp_ifv && ir;
    if (rd) begin
      buffered = 0;
      epoch++;
      exp_pc  = tgt;
      exp_req = tgt;
    end else begin
      if (!(cur && pop_fire && buffered == 0)) begin
        if (cur) buffered++;
        if (pop_fire) buffered--;
      end
      if (pop_fire) begin
        exp_pc = exp_pc + 32'd4;
        ndeliv++;
      end
    end
    if (rsp_now) pend.delete(0);
    if (exp_rv && rr) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      r.addr = exp_req; r.ep = epoch; r.due = due;
      pend.push_back(r);
      last_due = due;
      exp_req = exp_req + 32'd4;
    end
    cyc++;
    first = 1'b0;
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int d0 = ndeliv;
    int b = 0;
    while (ndeliv < d0 + n && b < budget) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      b++;
    end
    chk(tag, (ndeliv - d0) >= n, 1'b1);
  endtask

  task automatic quiesce();
    int b = 0;
    while ((pend.size() > 0 || buffered > 0) && b < 100) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      b++;
    end
    chk("quiesce", pend.size() + buffered, 0);
  endtask

  // Exactly three requests in flight, none answering in the next cycle.
  task automatic setup3();
    lat_min = 4; lat_max = 4;
    quiesce();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("setup_inflight", pend.size(), 3);
  endtask

  initial begin
    int base, n0;
    logic [31:0] t, x;

    // 1: reset, sequential fetch with 2-cycle IMEM latency
    do_reset();
    lat_min = 2; lat_max = 2;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t1_idle_no_req", obs_rv, 1'b0);
    run_until("t1_stream", 8, 100);

    // 2: IF stalled -> credit caps issue at DEPTH, then drains in order
    base = pend.size() + buffered;
    n0 = n_dut_req;
    repeat (20) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_issued", n_dut_req - n0, DEPTH - base);
    chk("t2_blocked", obs_rv, 1'b0);
    run_until("t2_release", 4, 20);
    n0 = n_dut_req;
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t2_resume", n_dut_req > n0, 1'b1);

    // 3: redirect with three outstanding -> all three dropped
    setup3();
    step(1'b0, 1'b1, 1'b1, 32'h0040_0100);
    chk("t3_discard", stale_cnt(), 3);
    lat_min = 2; lat_max = 2;
    run_until("t3_new_path", 3, 60);

    // 4: redirect coinciding with the only response -> straight back to FETCH
    quiesce();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0040_0140);
    chk("t4_discard", stale_cnt(), 0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_direct_fetch", obs_rv, 1'b1);
    run_until("t4_new_path", 3, 60);

    // 5: second redirect while draining -> latest target wins
    setup3();
    step(1'b0, 1'b1, 1'b1, 32'h0040_0180);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0040_0200);
    chk("t5_discard", stale_cnt(), 1);
    lat_min = 2; lat_max = 2;
    run_until("t5_new_path", 4, 60);

    // 6: reset in the middle of a drain
    setup3();
    step(1'b0, 1'b1, 1'b1, 32'h0040_0240);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    do_reset();
    lat_min = 2; lat_max = 2;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_idle_no_req", obs_rv, 1'b0);
    run_until("t6_restart", 4, 60);

    // PC wrap-around at the top of the address space
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    run_until("wrap_stream", 4, 60);

    // Randomized traffic: IMEM latency 1..4, random stalls and redirects
    lat_min = 1; lat_max = 4;
    n0 = ndeliv;
    for (int i = 0; i < 2000; i++) begin
      x = $urandom_range(0, 1023);
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : (RPC + (x << 2));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, t);
    end
    chk("rand_progress", (ndeliv - n0) > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
